interfaz_dac_spi: RTL and testbench

Serial transmitter that takes the filtered sample `Yk` produced by the low-pass filter datapath on its one-cycle `Bandera_Listo` strobe and drives it to an external 12-bit SPI DAC (DAC121S101-style, 16-bit frame). It is the output-side counterpart of the filter's ADC sample strobe. It converts signed fixed-point to offset-binary 12-bit, frames it, and generates SCLK/SYNC_n/DIN with a single-entry pending buffer for samples that arrive mid-frame.

---
 rtl/dac_pkg.sv | 36 +++
 rtl/interfaz_dac_spi_divisor_sclk.sv | 42 ++++
 rtl/interfaz_dac_spi.sv | 175 +++++++++++++++++
 tb/tb_interfaz_dac_spi.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared constants, FSM state type and the sample-to-DAC-code
// conversion for the SPI DAC transmitter.
// Optional feature macro: DAC_SAT_EN (clamp out-of-range samples instead of wrapping).
package dac_pkg;

   localparam int         FRAME_BITS  = 16;
   localparam int         DAC_BITS    = 12;
   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam int         ANCHO_EXT   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } estado_t;

   // Takes the already-scaled sample (LSB = one DAC step, sign-extended to
   // ANCHO_EXT bits) and returns the 12-bit offset-binary code.
   function automatic logic [DAC_BITS-1:0] a_offset_binario(input logic signed [ANCHO_EXT-1:0] s);
      logic signed [ANCHO_EXT-1:0] lim;
`ifdef DAC_SAT_EN
      if (s > 32'sd2047) begin
         lim = 32'sd2047;
      end else if (s < -32'sd2048) begin
         lim = -32'sd2048;
      end else begin
         lim = s;
      end
`else
      // Without clamping the low 12 bits are taken as-is, so overrange wraps.
      lim = s;
`endif
      return {~lim[DAC_BITS-1], lim[DAC_BITS-2:0]};
   endfunction

endpackage

// File: rtl/interfaz_dac_spi_divisor_sclk.sv
// divisor_sclk: counts DIV system clocks and flags the last cycle of each
// SCLK half-period. Restarting aligns the first half-period to a frame start.
module divisor_sclk #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic reiniciar,
   output logic tick_mitad
);

   localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0]  ULTIMO = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_sig_s;
   logic          tick_r;

   // Next count: wrap at the end of a half-period or restart on a frame start.
   always_comb begin
      cnt_sig_s = cnt_r;
      if (reiniciar || (cnt_r == ULTIMO)) begin
         cnt_sig_s = {CW{1'b0}};
      end else begin
         cnt_sig_s = cnt_r + CW'(1);
      end
   end

   // Count register and registered tick (high while the count sits on its last value).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= {CW{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_sig_s;
         tick_r <= (cnt_sig_s == ULTIMO);
      end
   end

   assign tick_mitad = tick_r;

endmodule

// File: rtl/interfaz_dac_spi.sv
// interfaz_dac_spi: converts the filter output Yk into a 16-bit DAC121S101
// style frame and shifts it out over SCLK/SYNC_n/DIN, with a one-entry
// pending buffer for samples that arrive while a frame is in flight.
// Optional feature macro: DAC_SAT_EN (see dac_pkg::a_offset_binario).
module interfaz_dac_spi
   import dac_pkg::*;
#(
   parameter int N   = 25,
   parameter int F   = 15,
   parameter int DIV = 4
) (
   input  logic                Clk,
   input  logic                Rst_n,
   input  logic signed [N-1:0] Yk,
   input  logic                Bandera_Listo,
   output logic                SCLK,
   output logic                SYNC_n,
   output logic                DIN,
   output logic                Ocupado,
   output logic                Enviado,
   output logic                Sobrecarga
);

   localparam int            DESP    = F - (DAC_BITS - 1);
   localparam int            GW      = $clog2(2 * DIV);
   localparam logic [GW-1:0] GAP_ULT = GW'(2 * DIV - 1);
   localparam logic [GW-1:0] GAP_PEN = GW'(2 * DIV - 2);

   estado_t                 estado_r;
   logic [FRAME_BITS-1:0]   trama_r;
   logic [FRAME_BITS-1:0]   pend_r;
   logic                    pend_v_r;
   logic [3:0]              bit_cnt_r;
   logic                    fase_r;      // 0: SCLK high half, 1: SCLK low half
   logic [GW-1:0]           gap_cnt_r;
   logic                    sclk_r;
   logic                    sync_n_r;
   logic                    din_r;
   logic                    ocupado_r;
   logic                    enviado_r;
   logic                    sobrecarga_r;

   logic signed [N-1:0]         desp_s;
   logic signed [ANCHO_EXT-1:0] ext_s;
   logic [FRAME_BITS-1:0]       trama_s;
   logic [FRAME_BITS-1:0]       carga_s;
   logic                        fin_gap_s;
   logic                        consumo_s;
   logic                        inicio_s;
   logic                        almacena_s;
   logic                        tick_s;

   // Sample conversion and frame-start / pending-buffer decisions.
   always_comb begin
      desp_s     = Yk >>> DESP;
      ext_s      = ANCHO_EXT'(desp_s);
      trama_s    = {2'b00, MODE_NORMAL, a_offset_binario(ext_s)};
      fin_gap_s  = (estado_r == GAP) && (gap_cnt_r == GAP_ULT);
      consumo_s  = fin_gap_s && pend_v_r;
      // A strobe on the last gap cycle with nothing pending starts the next
      // frame directly instead of parking in the buffer.
      inicio_s   = ((estado_r == IDLE) && Bandera_Listo) ||
                   (fin_gap_s && (pend_v_r || Bandera_Listo));
      almacena_s = Bandera_Listo &&
                   ((estado_r == SHIFT) || ((estado_r == GAP) && (!fin_gap_s || pend_v_r)));
      if (consumo_s) begin
         carga_s = pend_r;
      end else begin
         carga_s = trama_s;
      end
   end

   divisor_sclk #(.DIV(DIV)) u_divisor (
      .clk        (Clk),
      .rst_n      (Rst_n),
      .reiniciar  (inicio_s),
      .tick_mitad (tick_s)
   );

   // Frame FSM, pending buffer and all registered SPI/status outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         estado_r     <= IDLE;
         trama_r      <= {FRAME_BITS{1'b0}};
         pend_r       <= {FRAME_BITS{1'b0}};
         pend_v_r     <= 1'b0;
         bit_cnt_r    <= 4'd0;
         fase_r       <= 1'b0;
         gap_cnt_r    <= {GW{1'b0}};
         sclk_r       <= 1'b1;
         sync_n_r     <= 1'b1;
         din_r        <= 1'b0;
         ocupado_r    <= 1'b0;
         enviado_r    <= 1'b0;
         sobrecarga_r <= 1'b0;
      end else begin
         enviado_r    <= 1'b0;
         sobrecarga_r <= 1'b0;

         if (almacena_s) begin
            pend_r       <= trama_s;
            pend_v_r     <= 1'b1;
            sobrecarga_r <= pend_v_r && !consumo_s;
         end else if (consumo_s) begin
            pend_v_r <= 1'b0;
         end else begin
            pend_v_r <= pend_v_r;
         end

         if (inicio_s) begin
            estado_r  <= SHIFT;
            trama_r   <= carga_s;
            din_r     <= carga_s[FRAME_BITS-1];
            sclk_r    <= 1'b1;
            sync_n_r  <= 1'b0;
            ocupado_r <= 1'b1;
            bit_cnt_r <= 4'd15;
            fase_r    <= 1'b0;
         end else begin
            case (estado_r)
               IDLE: begin
                  sclk_r   <= 1'b1;
                  sync_n_r <= 1'b1;
               end
               SHIFT: begin
                  if (tick_s) begin
                     if (!fase_r) begin
                        sclk_r <= 1'b0;
                        fase_r <= 1'b1;
                     end else if (bit_cnt_r == 4'd0) begin
                        estado_r  <= GAP;
                        sclk_r    <= 1'b1;
                        sync_n_r  <= 1'b1;
                        din_r     <= 1'b0;
                        fase_r    <= 1'b0;
                        gap_cnt_r <= {GW{1'b0}};
                     end else begin
                        bit_cnt_r <= bit_cnt_r - 4'd1;
                        sclk_r    <= 1'b1;
                        fase_r    <= 1'b0;
                        din_r     <= trama_r[FRAME_BITS-2];
                        trama_r   <= {trama_r[FRAME_BITS-2:0], 1'b0};
                     end
                  end
               end
               GAP: begin
                  if (fin_gap_s) begin
                     estado_r  <= IDLE;
                     ocupado_r <= 1'b0;
                  end else begin
                     gap_cnt_r <= gap_cnt_r + GW'(1);
                     if (gap_cnt_r == GAP_PEN) begin
                        enviado_r <= 1'b1;
                     end
                  end
               end
               default: begin
                  estado_r  <= IDLE;
                  sclk_r    <= 1'b1;
                  sync_n_r  <= 1'b1;
                  ocupado_r <= 1'b0;
               end
            endcase
         end
      end
   end

   assign SCLK       = sclk_r;
   assign SYNC_n     = sync_n_r;
   assign DIN        = din_r;
   assign Ocupado    = ocupado_r;
   assign Enviado    = enviado_r;
   assign Sobrecarga = sobrecarga_r;

endmodule

// File: tb/tb_interfaz_dac_spi.sv
// Directed self-checking bench for interfaz_dac_spi (N=25, F=15, DIV=4).
// Expected overrange code follows the DAC_SAT_EN macro of the build.
module tb_interfaz_dac_spi;

   localparam int N   = 25;
   localparam int DIV = 4;
   localparam int LOW_CYC = 32 * DIV;
   localparam int ENV_K   = 34 * DIV;

   logic                Clk = 1'b0;
   logic                Rst_n = 1'b0;
   logic signed [N-1:0] Yk = '0;
   logic                Bandera_Listo = 1'b0;
   logic                SCLK, SYNC_n, DIN, Ocupado, Enviado, Sobrecarga;

   int total  = 0;
   int passed = 0;

   interfaz_dac_spi #(.N(N), .F(15), .DIV(DIV)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Yk(Yk), .Bandera_Listo(Bandera_Listo),
      .SCLK(SCLK), .SYNC_n(SYNC_n), .DIN(DIN), .Ocupado(Ocupado),
      .Enviado(Enviado), .Sobrecarga(Sobrecarga)
   );

   always #5 Clk = ~Clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One-cycle strobe; returns at the negedge of the first frame cycle.
   task automatic strobe(input logic signed [N-1:0] v);
      @(negedge Clk);
      Yk = v;
      Bandera_Listo = 1'b1;
      @(negedge Clk);
      Bandera_Listo = 1'b0;
   endtask

   // Records one frame starting at the current negedge (k=1) until Enviado.
   task automatic capture(output logic [15:0] fr, output int falls, output int low,
                          output int env_k, output int sob, output bit unst,
                          output bit idle_gap, output bit to);
      logic prev_sclk, prev_din;
      int   k;
      fr = 16'h0000; falls = 0; low = 0; env_k = -1; sob = 0;
      unst = 1'b0; idle_gap = 1'b0; to = 1'b0;
      prev_sclk = 1'b1; prev_din = DIN; k = 1;
      while (env_k < 0 && !to) begin
         if (!SYNC_n) low++;
         if (Sobrecarga) sob++;
         if (!Ocupado) idle_gap = 1'b1;
         if (prev_sclk && !SCLK) begin
            fr = {fr[14:0], DIN};
            falls++;
            if (DIN !== prev_din) unst = 1'b1;
         end
         if (!prev_sclk && !SCLK && (DIN !== prev_din)) unst = 1'b1;
         if (Enviado) begin
            env_k = k;
         end else begin
            prev_sclk = SCLK; prev_din = DIN; k++;
            if (k > 400) to = 1'b1;
            else @(negedge Clk);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge Clk);
      total++; if (SCLK !== 1'b1)    $display("FAIL reset_sclk: got %b expected 1", SCLK); else passed++;
      total++; if (SYNC_n !== 1'b1)  $display("FAIL reset_sync: got %b expected 1", SYNC_n); else passed++;
      total++; if (DIN !== 1'b0)     $display("FAIL reset_din: got %b expected 0", DIN); else passed++;
      total++; if (Ocupado !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Ocupado); else passed++;
      total++; if (Enviado !== 1'b0) $display("FAIL reset_sent: got %b expected 0", Enviado); else passed++;
      total++; if (Sobrecarga !== 1'b0) $display("FAIL reset_ovl: got %b expected 0", Sobrecarga); else passed++;
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_zero();
      logic [15:0] fr; int falls, low, env, sob; bit unst, gap, to;
      strobe(25'sd0);
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (to)                $display("FAIL zero_timeout: got timeout expected Enviado"); else passed++;
      total++; if (fr !== 16'h0800)   $display("FAIL zero_frame: got %h expected 0800", fr); else passed++;
      total++; if (falls !== 16)      $display("FAIL zero_falls: got %0d expected 16", falls); else passed++;
      total++; if (low !== LOW_CYC)   $display("FAIL zero_sync_low: got %0d expected %0d", low, LOW_CYC); else passed++;
      total++; if (env !== ENV_K)     $display("FAIL zero_sent_time: got %0d expected %0d", env, ENV_K); else passed++;
      total++; if (unst)              $display("FAIL zero_din_stable: got unstable expected stable"); else passed++;
      total++; if (gap)               $display("FAIL zero_busy: got low during frame expected high"); else passed++;
      @(negedge Clk);
      total++; if (Ocupado !== 1'b0)  $display("FAIL zero_busy_end: got %b expected 0", Ocupado); else passed++;
      total++; if (SYNC_n !== 1'b1)   $display("FAIL zero_sync_end: got %b expected 1", SYNC_n); else passed++;
   endtask

   task automatic test_codes();
      logic [15:0] fr; int falls, low, env, sob; bit unst, gap, to;
      logic [15:0] exp_sat;
      strobe(25'sd16384);
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== 16'h0C00)   $display("FAIL half_frame: got %h expected 0C00", fr); else passed++;
      total++; if (unst)              $display("FAIL half_din_stable: got unstable expected stable"); else passed++;
      total++; if (env !== ENV_K)     $display("FAIL half_sent_time: got %0d expected %0d", env, ENV_K); else passed++;
      @(negedge Clk);
      strobe(-25'sd32768);
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== 16'h0000)   $display("FAIL neg_frame: got %h expected 0000", fr); else passed++;
      total++; if (unst)              $display("FAIL neg_din_stable: got unstable expected stable"); else passed++;
      @(negedge Clk);
`ifdef DAC_SAT_EN
      exp_sat = 16'h0FFF;
`else
      exp_sat = 16'h0800;
`endif
      strobe(25'sd65536);
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== exp_sat)    $display("FAIL over_frame: got %h expected %h", fr, exp_sat); else passed++;
      @(negedge Clk);
   endtask

   task automatic test_back_to_back();
      logic [15:0] fr; int falls, low, env, sob; bit unst, gap, to;
      strobe(25'sd16);
      fork
         capture(fr, falls, low, env, sob, unst, gap, to);
         begin
            repeat (10) @(negedge Clk);
            Yk = 25'sd32; Bandera_Listo = 1'b1;
            @(negedge Clk);
            Bandera_Listo = 1'b0;
            repeat (30) @(negedge Clk);
            Yk = 25'sd48; Bandera_Listo = 1'b1;
            @(negedge Clk);
            Bandera_Listo = 1'b0;
         end
      join
      total++; if (fr !== 16'h0801)   $display("FAIL b2b_first_frame: got %h expected 0801", fr); else passed++;
      total++; if (sob !== 1)         $display("FAIL b2b_ovl_count: got %0d expected 1", sob); else passed++;
      total++; if (gap)               $display("FAIL b2b_busy_first: got low expected high"); else passed++;
      // Strobe during the Enviado cycle, the same cycle the buffer is consumed.
      Yk = 25'sd0; Bandera_Listo = 1'b1;
      @(negedge Clk);
      Bandera_Listo = 1'b0;
      total++; if (SYNC_n !== 1'b0)   $display("FAIL b2b_sync_fall: got %b expected 0", SYNC_n); else passed++;
      total++; if (Ocupado !== 1'b1)  $display("FAIL b2b_busy_link: got %b expected 1", Ocupado); else passed++;
      total++; if (Sobrecarga !== 1'b0) $display("FAIL b2b_consume_ovl: got %b expected 0", Sobrecarga); else passed++;
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== 16'h0803)   $display("FAIL b2b_second_frame: got %h expected 0803", fr); else passed++;
      total++; if (sob !== 0)         $display("FAIL b2b_second_ovl: got %0d expected 0", sob); else passed++;
      total++; if (gap)               $display("FAIL b2b_busy_second: got low expected high"); else passed++;
      total++; if (env !== ENV_K)     $display("FAIL b2b_second_time: got %0d expected %0d", env, ENV_K); else passed++;
      @(negedge Clk);
      total++; if (SYNC_n !== 1'b0)   $display("FAIL b2b_third_start: got %b expected 0", SYNC_n); else passed++;
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== 16'h0800)   $display("FAIL b2b_third_frame: got %h expected 0800", fr); else passed++;
      @(negedge Clk);
      total++; if (Ocupado !== 1'b0)  $display("FAIL b2b_busy_end: got %b expected 0", Ocupado); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] fr; int falls, low, env, sob; bit unst, gap, to;
      strobe(25'sd8192);
      repeat (69) @(negedge Clk);
      total++; if (SCLK !== 1'b0)     $display("FAIL mid_pre_sclk: got %b expected 0", SCLK); else passed++;
      total++; if (SYNC_n !== 1'b0)   $display("FAIL mid_pre_sync: got %b expected 0", SYNC_n); else passed++;
      Rst_n = 1'b0;
      #1;
      total++; if (SCLK !== 1'b1)     $display("FAIL mid_rst_sclk: got %b expected 1", SCLK); else passed++;
      total++; if (SYNC_n !== 1'b1)   $display("FAIL mid_rst_sync: got %b expected 1", SYNC_n); else passed++;
      total++; if (Ocupado !== 1'b0)  $display("FAIL mid_rst_busy: got %b expected 0", Ocupado); else passed++;
      total++; if (DIN !== 1'b0)      $display("FAIL mid_rst_din: got %b expected 0", DIN); else passed++;
      @(negedge Clk);
      Rst_n = 1'b1;
      repeat (2) @(negedge Clk);
      total++; if (SYNC_n !== 1'b1)   $display("FAIL mid_idle_sync: got %b expected 1", SYNC_n); else passed++;
      strobe(-25'sd32768);
      capture(fr, falls, low, env, sob, unst, gap, to);
      total++; if (fr !== 16'h0000)   $display("FAIL mid_after_frame: got %h expected 0000", fr); else passed++;
      total++; if (falls !== 16)      $display("FAIL mid_after_falls: got %0d expected 16", falls); else passed++;
      total++; if (low !== LOW_CYC)   $display("FAIL mid_after_low: got %0d expected %0d", low, LOW_CYC); else passed++;
      total++; if (env !== ENV_K)     $display("FAIL mid_after_time: got %0d expected %0d", env, ENV_K); else passed++;
      @(negedge Clk);
   endtask

   initial begin
      test_reset();
      test_zero();
      test_codes();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
